// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and the MEM-stage load/store path.
// Optional macro ARB_FAIR_EN bounds consecutive data grants while fetch waits to FAIR_LIMIT.
module mem_port_arbiter #(
  parameter int XLEN       = 32,
  parameter int FAIR_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  input  logic            if_kill,
  output logic [XLEN-1:0] if_rdata,
  output logic            if_valid,
  output logic            if_stall,
  input  logic            MEM_ld,
  input  logic            MEM_str,
  input  logic            MEM_byt,
  input  logic [XLEN-1:0] MEM_alu_out,
  input  logic [XLEN-1:0] MEM_b2,
  output logic [XLEN-1:0] MEM_rdata,
  output logic            MEM_stall,
  output logic            m_req,
  output logic            m_we,
  output logic            m_byte,
  output logic [XLEN-1:0] m_addr,
  output logic [XLEN-1:0] m_wdata,
  input  logic [XLEN-1:0] m_rdata,
  input  logic            m_ready
);
  typedef enum logic [2:0] {IDLE, D_BUSY, D_DONE, I_BUSY, I_DONE} state_t;

  typedef struct packed {
    logic            req;
    logic            we;
    logic            byt;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } mreq_t;

  state_t state, state_nxt;
  mreq_t  mreq;
  logic   data_req, grant_d, grant_i, done_i, kill_seen, fair_force;

  assign data_req = MEM_ld | MEM_str;
  assign grant_d  = (state == IDLE) && (state_nxt == D_BUSY);
  assign grant_i  = (state == IDLE) && (state_nxt == I_BUSY);
  assign done_i   = (state == I_BUSY) && (state_nxt == I_DONE);

`ifdef ARB_FAIR_EN
  localparam int CW = $clog2(FAIR_LIMIT + 1);
  logic [CW-1:0] fair_cnt;

  // Counts data grants that overtook a waiting fetch; saturates at FAIR_LIMIT
  // because the next arbitration is then forced to fetch.
  assign fair_force = (fair_cnt == CW'(FAIR_LIMIT));

  always_ff @(posedge clk) begin
    if (rst)                    fair_cnt <= '0;
    else if (grant_i)           fair_cnt <= '0;
    else if (grant_d && if_req) fair_cnt <= fair_cnt + 1'b1;
  end
`else
  // Strict data priority: this folds to constant 0.
  assign fair_force = (FAIR_LIMIT < 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (fair_force && if_req) state_nxt = I_BUSY;
        else if (data_req)        state_nxt = D_BUSY;
        else if (if_req)          state_nxt = I_BUSY;
      end
      D_BUSY:  if (m_ready) state_nxt = D_DONE;
      I_BUSY:  if (m_ready) state_nxt = (kill_seen || if_kill) ? IDLE : I_DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    MEM_stall = data_req && (state != D_DONE);
    if_stall  = if_req && (state != I_DONE);
    if_valid  = (state == I_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mreq      <= '0;
      kill_seen <= 1'b0;
      MEM_rdata <= '0;
      if_rdata  <= '0;
    end else begin
      if (grant_d) begin
        mreq.req   <= 1'b1;
        mreq.we    <= MEM_str;
        mreq.byt   <= MEM_byt;
        mreq.addr  <= MEM_alu_out;
        mreq.wdata <= MEM_b2;
      end else if (grant_i) begin
        mreq.req   <= 1'b1;
        mreq.we    <= 1'b0;
        mreq.byt   <= 1'b0;
        mreq.addr  <= if_addr;
        mreq.wdata <= '0;
      end else if (m_ready && (state == D_BUSY || state == I_BUSY)) begin
        mreq.req <= 1'b0;
        mreq.we  <= 1'b0;
      end
      // A kill in any fetch-busy cycle suppresses the result even though the access still finishes.
      if (state == IDLE)                  kill_seen <= 1'b0;
      else if (state == I_BUSY && if_kill) kill_seen <= 1'b1;
      if (state == D_BUSY && m_ready && !mreq.we) MEM_rdata <= m_rdata;
      if (done_i)                                 if_rdata  <= m_rdata;
    end
  end

  assign m_req   = mreq.req;
  assign m_we    = mreq.we;
  assign m_byte  = mreq.byt;
  assign m_addr  = mreq.addr;
  assign m_wdata = mreq.wdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int XLEN       = 32;
  localparam int FAIR_LIMIT = 4;
`ifdef ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic if_req, if_kill, MEM_ld, MEM_str, MEM_byt, m_ready;
  logic [XLEN-1:0] if_addr, MEM_alu_out, MEM_b2, m_rdata;
  logic [XLEN-1:0] if_rdata, MEM_rdata, m_addr, m_wdata;
  logic if_valid, if_stall, MEM_stall, m_req, m_we, m_byte;
  int vectors = 0, miscompares = 0;
  logic [31:0] mem [logic [31:0]];

  always #5 clk = ~clk;

  mem_port_arbiter #(.XLEN(XLEN), .FAIR_LIMIT(FAIR_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
    .MEM_ld(MEM_ld), .MEM_str(MEM_str), .MEM_byt(MEM_byt),
    .MEM_alu_out(MEM_alu_out), .MEM_b2(MEM_b2),
    .MEM_rdata(MEM_rdata), .MEM_stall(MEM_stall),
    .m_req(m_req), .m_we(m_we), .m_byte(m_byte), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

  task automatic clear_inputs();
    if_req = 0; if_addr = '0; if_kill = 0;
    MEM_ld = 0; MEM_str = 0; MEM_byt = 0; MEM_alu_out = '0; MEM_b2 = '0;
    m_rdata = '0; m_ready = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    @(negedge clk);
    vectors++; if ({m_req, m_we, m_byte, m_addr, m_wdata, if_rdata, if_valid, MEM_rdata} !== 132'd0) begin miscompares++; $display("FAIL rst_outputs got %h want 0", {m_req, m_we, m_byte, m_addr, m_wdata, if_rdata, if_valid, MEM_rdata}); end
    rst = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      vectors++; if ({m_req, if_stall, MEM_stall, if_valid} !== 4'b0) begin miscompares++; $display("FAIL idle_c%0d req/istall/mstall/ivalid got %b want 0000", c, {m_req, if_stall, MEM_stall, if_valid}); end
    end
  endtask

  task automatic test_load();
    MEM_ld = 1; MEM_alu_out = 32'h100;
    #1;
    vectors++; if (MEM_stall !== 1'b1) begin miscompares++; $display("FAIL ld_stall_idle got %b want 1", MEM_stall); end
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      vectors++; if ({m_req, m_we, m_addr} !== {1'b1, 1'b0, 32'h100}) begin miscompares++; $display("FAIL ld_busy%0d req/we/addr got %b/%b/%h want 1/0/100", c, m_req, m_we, m_addr); end
      vectors++; if (MEM_stall !== 1'b1) begin miscompares++; $display("FAIL ld_stall_busy%0d got %b want 1", c, MEM_stall); end
      if (c == 3) begin m_ready = 1; m_rdata = 32'hDEADBEEF; end
    end
    @(negedge clk);
    m_ready = 0; m_rdata = '0;
    vectors++; if (MEM_stall !== 1'b0) begin miscompares++; $display("FAIL ld_stall_done got %b want 0", MEM_stall); end
    vectors++; if (MEM_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL ld_rdata got %h want deadbeef", MEM_rdata); end
    vectors++; if (m_req !== 1'b0) begin miscompares++; $display("FAIL ld_req_done got %b want 0", m_req); end
    MEM_ld = 0;
    @(negedge clk);
    vectors++; if ({MEM_stall, MEM_rdata} !== {1'b0, 32'hDEADBEEF}) begin miscompares++; $display("FAIL ld_hold stall/rdata got %b/%h want 0/deadbeef", MEM_stall, MEM_rdata); end
  endtask

  task automatic test_store_byte();
    MEM_str = 1; MEM_byt = 1; MEM_b2 = 32'h5A; MEM_alu_out = 32'h203;
    @(negedge clk);
    vectors++; if ({m_req, m_we, m_byte, m_addr, m_wdata} !== {3'b111, 32'h203, 32'h5A}) begin miscompares++; $display("FAIL st_fields got %b%b%b/%h/%h want 111/203/5a", m_req, m_we, m_byte, m_addr, m_wdata); end
    m_ready = 1; m_rdata = 32'h12345678;
    @(negedge clk);
    m_ready = 0;
    vectors++; if ({m_req, m_we, MEM_stall} !== 3'b000) begin miscompares++; $display("FAIL st_done req/we/stall got %b want 000", {m_req, m_we, MEM_stall}); end
    vectors++; if (MEM_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL st_rdata_kept got %h want deadbeef", MEM_rdata); end
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_simul();
    if_req = 1; if_addr = 32'h40; MEM_ld = 1; MEM_alu_out = 32'h300;
    @(negedge clk);
    vectors++; if ({m_req, m_addr, if_stall} !== {1'b1, 32'h300, 1'b1}) begin miscompares++; $display("FAIL sim_data_first req/addr/istall got %b/%h/%b want 1/300/1", m_req, m_addr, if_stall); end
    m_ready = 1; m_rdata = 32'h11112222;
    @(negedge clk);
    m_ready = 0;
    vectors++; if ({MEM_rdata, if_stall, if_valid} !== {32'h11112222, 1'b1, 1'b0}) begin miscompares++; $display("FAIL sim_ddone rdata/istall/ivalid got %h/%b/%b want 11112222/1/0", MEM_rdata, if_stall, if_valid); end
    MEM_ld = 0;
    @(negedge clk);
    vectors++; if ({m_req, if_stall} !== 2'b01) begin miscompares++; $display("FAIL sim_idle req/istall got %b want 01", {m_req, if_stall}); end
    @(negedge clk);
    vectors++; if ({m_req, m_we, m_addr} !== {2'b10, 32'h40}) begin miscompares++; $display("FAIL sim_fetch req/we/addr got %b/%b/%h want 1/0/40", m_req, m_we, m_addr); end
    m_ready = 1; m_rdata = 32'h13;
    @(negedge clk);
    m_ready = 0;
    vectors++; if ({if_valid, if_stall, if_rdata} !== {2'b10, 32'h13}) begin miscompares++; $display("FAIL sim_idone valid/stall/rdata got %b/%b/%h want 1/0/13", if_valid, if_stall, if_rdata); end
    if_req = 0;
    @(negedge clk);
    vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL sim_valid_pulse got %b want 0", if_valid); end
  endtask

  task automatic test_kill();
    if_req = 1; if_addr = 32'h40;
    @(negedge clk);
    vectors++; if ({m_req, m_addr} !== {1'b1, 32'h40}) begin miscompares++; $display("FAIL kill_grant req/addr got %b/%h want 1/40", m_req, m_addr); end
    if_kill = 1;
    @(negedge clk);
    if_kill = 0; m_ready = 1; m_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    m_ready = 0;
    vectors++; if ({if_valid, m_req, if_stall, if_rdata} !== {3'b001, 32'h13}) begin miscompares++; $display("FAIL kill_done valid/req/stall/rdata got %b/%b/%b/%h want 0/0/1/13", if_valid, m_req, if_stall, if_rdata); end
    if_req = 0;
    @(negedge clk);
    vectors++; if ({if_valid, m_req} !== 2'b00) begin miscompares++; $display("FAIL kill_idle valid/req got %b want 00", {if_valid, m_req}); end
  endtask

  task automatic test_reset_mid();
    MEM_ld = 1; MEM_alu_out = 32'h500;
    @(negedge clk);
    vectors++; if (m_req !== 1'b1) begin miscompares++; $display("FAIL rmid_busy req got %b want 1", m_req); end
    rst = 1;
    @(negedge clk);
    vectors++; if ({m_req, MEM_rdata, if_rdata} !== {1'b0, 64'd0}) begin miscompares++; $display("FAIL rmid_abandon req/mrd/ird got %b/%h/%h want 0/0/0", m_req, MEM_rdata, if_rdata); end
    rst = 0; clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_fair();
    bit got, exp_f;
    clear_inputs();
    if_req = 1; if_addr = 32'h80; MEM_ld = 1; MEM_alu_out = 32'h600;
    for (int g = 0; g < 6; g++) begin
      got = 0;
      for (int w = 0; w < 10 && !got; w++) begin
        @(negedge clk);
        if (m_req === 1'b1) got = 1;
      end
      exp_f = FAIR && (g == FAIR_LIMIT);
      vectors++; if (!got || ((m_addr === 32'h80) != exp_f)) begin miscompares++; $display("FAIL fair_grant%0d seen=%0d fetch=%0d want seen=1 fetch=%0d", g, got, m_addr === 32'h80, exp_f); end
      m_ready = 1; m_rdata = 32'(g);
      @(negedge clk);
      m_ready = 0;
    end
    clear_inputs();
    repeat (3) @(negedge clk);
  endtask

  // Transaction-level model: the bench plays both the pipeline (holding requests until
  // their stall drops) and the memory (random latency, word/byte storage).
  task automatic test_random(input int cycles);
    bit d_pend, d_str, d_byt, f_pend, mbusy, d_done, f_done, want_d, t_d, t_we, t_byt;
    logic [31:0] d_addr, d_wdata, f_addr, t_addr, t_wdata, exp_mrd, exp_ird, rd;
    logic [98:0] exp_f;
    int lat, fcnt;
    {d_pend, d_str, d_byt, f_pend, mbusy, d_done, f_done, t_d, t_we, t_byt} = '0;
    d_addr = '0; d_wdata = '0; f_addr = '0; t_addr = '0; t_wdata = '0;
    exp_mrd = '0; exp_ird = '0; lat = 0; fcnt = 0;
    clear_inputs();
    rst = 1;
    @(negedge clk);
    rst = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      vectors++; if (if_valid !== f_done) begin miscompares++; $display("FAIL rnd_if_valid c%0d got %b want %b", c, if_valid, f_done); end
      vectors++; if (MEM_stall !== (d_pend && !d_done)) begin miscompares++; $display("FAIL rnd_mem_stall c%0d got %b want %b", c, MEM_stall, d_pend && !d_done); end
      vectors++; if (if_stall !== (f_pend && !f_done)) begin miscompares++; $display("FAIL rnd_if_stall c%0d got %b want %b", c, if_stall, f_pend && !f_done); end
      if (d_done) begin
        vectors++; if (MEM_rdata !== exp_mrd) begin miscompares++; $display("FAIL rnd_mem_rdata c%0d got %h want %h", c, MEM_rdata, exp_mrd); end
        d_pend = 0;
      end
      if (f_done) begin
        vectors++; if (if_rdata !== exp_ird) begin miscompares++; $display("FAIL rnd_if_rdata c%0d got %h want %h", c, if_rdata, exp_ird); end
        f_pend = 0;
      end
      d_done = 0; f_done = 0; m_ready = 0;

      if (!mbusy && m_req === 1'b1) begin
        want_d = d_pend && !(FAIR && f_pend && fcnt == FAIR_LIMIT);
        t_d = want_d;
        t_addr  = want_d ? d_addr : f_addr;
        t_we    = want_d && d_str;
        t_byt   = want_d && d_byt;
        t_wdata = want_d ? d_wdata : 32'd0;
        exp_f = {t_addr, t_we, t_byt, t_wdata, 1'b1};
        vectors++; if (!(d_pend || f_pend) || {m_addr, m_we, m_byte, m_wdata, m_req} !== exp_f) begin miscompares++; $display("FAIL rnd_grant c%0d got addr=%h we=%b byte=%b wdata=%h want addr=%h we=%b byte=%b wdata=%h", c, m_addr, m_we, m_byte, m_wdata, t_addr, t_we, t_byt, t_wdata); end
        if (want_d && f_pend) fcnt++;
        else if (!want_d)     fcnt = 0;
        mbusy = 1;
        lat = $urandom_range(0, 3);
      end

      if (mbusy) begin
        vectors++; if ({m_req, m_addr} !== {1'b1, t_addr}) begin miscompares++; $display("FAIL rnd_hold c%0d req/addr got %b/%h want 1/%h", c, m_req, m_addr, t_addr); end
        if (lat == 0) begin
          m_ready = 1;
          rd = mem.exists(t_addr) ? mem[t_addr] : {~t_addr[15:0], t_addr[15:0]};
          if (t_we) begin
            mem[t_addr] = t_byt ? {24'd0, t_wdata[7:0]} : t_wdata;
            m_rdata = $urandom;
          end else begin
            m_rdata = rd;
          end
          if (t_d) begin d_done = 1; if (!t_we) exp_mrd = rd; end
          else     begin f_done = 1; exp_ird = rd; end
          mbusy = 0;
        end else begin
          lat--;
        end
      end

      if (!d_pend && $urandom_range(0, 2) != 0) begin
        d_pend = 1; d_str = ($urandom_range(0, 2) == 0); d_byt = $urandom_range(0, 1) == 1;
        d_addr = 32'h1000 + 32'($urandom_range(0, 15) * 4); d_wdata = $urandom;
      end
      if (!f_pend && $urandom_range(0, 3) != 0) begin
        f_pend = 1; f_addr = 32'($urandom_range(0, 63) * 4);
      end
      MEM_ld = d_pend && !d_str; MEM_str = d_pend && d_str; MEM_byt = d_pend && d_byt;
      MEM_alu_out = d_addr; MEM_b2 = d_wdata;
      if_req = f_pend; if_addr = f_addr;
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_load();
    test_store_byte();
    test_simul();
    test_kill();
    test_reset_mid();
    test_fair();
    test_random(2000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port backing memory between instruction fetch (IF) and the MEM-stage load/store path.
- Sequences each access as request, wait for `m_ready`, then complete.
- Generates `if_stall` toward fetch and `MEM_stall` toward the EX/MEM pipeline register, holding each requester until its access completes.
- Sits between the core pipeline and the unified memory model.

Parameters:
XLEN, 32, data/address width
FAIR_LIMIT, 4, consecutive data grants allowed while IF waits (used only with ARB_FAIR_EN)

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
if_req  input  1  fetch request; held high with stable if_addr while if_stall=1
if_addr  input  XLEN  fetch address
if_kill  input  1  discard the in-flight fetch result (branch redirect)
if_rdata  output  XLEN  fetched instruction, registered
if_valid  output  1  one-cycle pulse: if_rdata valid for current if_addr
if_stall  output  1  fetch must hold
MEM_ld  input  1  MEM-stage load
MEM_str  input  1  MEM-stage store
MEM_byt  input  1  byte access (else word)
MEM_alu_out  input  XLEN  data address
MEM_b2  input  XLEN  store data
MEM_rdata  output  XLEN  load data, registered
MEM_stall  output  1  MEM stage must hold
m_req  output  1  memory request, registered
m_we  output  1  write enable, registered
m_byte  output  1  byte access, registered
m_addr  output  XLEN  address, registered
m_wdata  output  XLEN  write data, registered
m_rdata  input  XLEN  memory read data, valid with m_ready
m_ready  input  1  access complete this cycle

Behaviour:
- States: IDLE, D_BUSY, D_DONE, I_BUSY, I_DONE.
- Reset: state IDLE. All outputs are 0 next cycle: `m_req`, `m_we`, `m_byte`, `m_addr`, `m_wdata`, `if_rdata`, `if_valid`, `MEM_rdata`, fairness counter.
  - Reset mid-transaction abandons it; `m_req` drops next cycle.
- Arbitration in IDLE only:
  - `MEM_ld|MEM_str` → D_BUSY.
  - Else `if_req` → I_BUSY.
  - Else stay IDLE.
  - Data wins simultaneous requests, since it is the older instruction.
- On entering a BUSY state, register the request fields:
  - Data: `m_req=1`, `m_we=MEM_str`, `m_byte=MEM_byt`, `m_addr=MEM_alu_out`, `m_wdata=MEM_b2`.
  - Fetch: `m_req=1`, `m_we=0`, `m_byte=0`, `m_addr=if_addr`, `m_wdata=0`.
- BUSY:
  - Hold all `m_*` stable until `m_ready=1`.
  - `m_ready` may assert in the first BUSY cycle.
  - On `m_ready`, `m_req`/`m_we` clear next cycle.
  - D_BUSY → D_DONE; if load, capture `MEM_rdata <= m_rdata`.
  - I_BUSY → I_DONE, capturing `if_rdata <= m_rdata`, unless `if_kill` is seen in any I_BUSY cycle; then → IDLE with no capture and no `if_valid`.
- DONE states last one cycle, then IDLE. No grant is made in a DONE state.
- `MEM_stall = (MEM_ld|MEM_str) && state!=D_DONE` (combinational). The EX/MEM register advances at the D_DONE edge.
- `if_stall = if_req && state!=I_DONE` (combinational).
- `if_valid = (state==I_DONE)`.
- Stores leave `MEM_rdata` unchanged. `MEM_rdata` is held until the next load completes.
- Minimum latency, request to DONE: 2 cycles (IDLE→BUSY→DONE with immediate `m_ready`).
- A request dropped while BUSY (e.g. `if_req` falls) still completes its transaction; its result is written but ignored.

Optional Feature:
- Macro `ARB_FAIR_EN`.
- Defined:
  - Counter (`$clog2(FAIR_LIMIT+1)` bits) increments on each data grant made while `if_req=1`.
  - At `FAIR_LIMIT`, the next IDLE arbitration grants IF even if data is pending.
  - The counter clears on any IF grant and on reset.
- Undefined: strict data priority; no counter logic.

Test Plan:
- Reset, then idle → all outputs 0, `m_req` never asserted, `if_stall=0`, `MEM_stall=0`.
- `MEM_ld=1`, `MEM_alu_out=0x100`, memory returns `0xDEADBEEF` with `m_ready` on 3rd BUSY cycle → `m_addr=0x100`, `m_we=0`; `MEM_stall` high until the D_DONE cycle; `MEM_rdata=0xDEADBEEF` from D_DONE.
- `MEM_str=1`, `MEM_byt=1`, `MEM_b2=0x5A`, addr `0x203`, immediate `m_ready` → `m_we=1`, `m_byte=1`, `m_wdata=0x5A` for one cycle; `MEM_rdata` unchanged.
- `if_req` and `MEM_ld` asserted together → data transaction first, `if_stall` held; fetch issues on the IDLE after D_DONE; `if_valid` pulses once with correct data.
- `if_req`, addr `0x40`; `if_kill` during I_BUSY → transaction completes, no `if_valid`, `if_rdata` unchanged, back to IDLE.
- With `ARB_FAIR_EN`, `FAIR_LIMIT=4`: back-to-back loads plus continuous `if_req` → after 4 data grants, the 5th grant goes to IF. Without the macro, IF waits until loads stop.
